t06_sound_arbiter: RTL and testbench

//  Shares the single tone sequencer/clock-divider path among the game's sound sources.

---
 rtl/t06_sound_arbiter_if.sv | 23 ++
 rtl/t06_sound_arbiter.sv | 151 +++++++++++++++
 tb/tb_t06_sound_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t06_sound_arbiter_if.sv
// Request/status bundle between the game logic and the sound arbiter.
// The master side raises requests; the slave (arbiter) reports the selected sound and timing.
interface t06_sound_arbiter_if;
    logic       enable;
    logic       music_en;
    logic       good_req;
    logic       bad_req;
    logic       over_req;
    logic [2:0] sound_sel;
    logic       tick_o;
    logic       busy;
    logic       done_o;

    modport master (
        output enable, music_en, good_req, bad_req, over_req,
        input  sound_sel, tick_o, busy, done_o
    );

    modport slave (
        input  enable, music_en, good_req, bad_req, over_req,
        output sound_sel, tick_o, busy, done_o
    );
endinterface

// File: rtl/t06_sound_arbiter.sv
// Arbitrates music and collision/game-over effects onto the single tone sequencer path.
// Effects are timed in prescaler ticks; priority is OVER > BAD > GOOD > MUSIC.
module t06_sound_arbiter #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned GOOD_TICKS = 31,
    parameter int unsigned BAD_TICKS  = 31,
    parameter int unsigned OVER_TICKS = 96,
    parameter int unsigned CNT_W      = 19
) (
    input  logic               clk,
    input  logic               nrst,
    t06_sound_arbiter_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUSIC = 3'd1;
    localparam logic [2:0] S_GOOD  = 3'd2;
    localparam logic [2:0] S_BAD   = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GOOD_LOAD = CNT_W'(GOOD_TICKS - 1);
    localparam logic [CNT_W-1:0] BAD_LOAD  = CNT_W'(BAD_TICKS - 1);
    localparam logic [CNT_W-1:0] OVER_LOAD = CNT_W'(OVER_TICKS - 1);

    logic [2:0]       state,   state_n;
    logic [CNT_W-1:0] cnt,     cnt_n;
    logic [CNT_W-1:0] dur,     dur_n;
    logic             good_pend, good_pend_n;
    logic             bad_pend,  bad_pend_n;
    logic [2:0]       sel_q,   sel_n;
    logic             busy_q,  busy_n;
    logic             tick_c;
    logic             fin_c;
    logic             in_effect_c;

    // Tick and end-of-effect strobes decoded from the registered counters.
    assign tick_c      = bus.enable && (cnt == TICK_LAST);
    assign in_effect_c = (state == S_GOOD) || (state == S_BAD) || (state == S_OVER);
    assign fin_c       = tick_c && in_effect_c && (dur == '0);

    assign bus.tick_o    = tick_c;
    assign bus.done_o    = fin_c;
    assign bus.busy      = busy_q;
    assign bus.sound_sel = bus.enable ? sel_q : 3'd0;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Prescaler, duration, pending flags and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt       <= '0;
            dur       <= '0;
            good_pend <= 1'b0;
            bad_pend  <= 1'b0;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            dur       <= dur_n;
            good_pend <= good_pend_n;
            bad_pend  <= bad_pend_n;
            sel_q     <= sel_n;
            busy_q    <= busy_n;
        end
    end

    // Next-state, duration and pending logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dur_n       = dur;
        good_pend_n = good_pend;
        bad_pend_n  = bad_pend;

        if (bus.enable) begin
            cnt_n = tick_c ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            S_HALT: begin
                state_n = S_HALT;
            end
            S_OVER: begin
                if (bus.over_req) begin
                    dur_n = OVER_LOAD;
                end else if (fin_c) begin
                    state_n = S_HALT;
                end else if (tick_c) begin
                    dur_n = dur - CNT_W'(1);
                end
            end
            default: begin
                if (bus.over_req) begin
                    state_n     = S_OVER;
                    dur_n       = OVER_LOAD;
                    good_pend_n = 1'b0;
                    bad_pend_n  = 1'b0;
                end else if (bus.bad_req) begin
                    // Entry from below or restart of a running BAD; a coincident GOOD waits.
                    state_n    = S_BAD;
                    dur_n      = BAD_LOAD;
                    bad_pend_n = 1'b0;
                    if (bus.good_req) begin
                        good_pend_n = 1'b1;
                    end
                end else if (bus.good_req && (state != S_BAD)) begin
                    state_n     = S_GOOD;
                    dur_n       = GOOD_LOAD;
                    good_pend_n = 1'b0;
                end else begin
                    if (bus.good_req) begin
                        good_pend_n = 1'b1;
                    end
                    if ((state == S_GOOD) || (state == S_BAD)) begin
                        if (fin_c) begin
                            if (bad_pend) begin
                                state_n    = S_BAD;
                                dur_n      = BAD_LOAD;
                                bad_pend_n = 1'b0;
                            end else if (good_pend_n) begin
                                state_n     = S_GOOD;
                                dur_n       = GOOD_LOAD;
                                good_pend_n = 1'b0;
                            end else begin
                                state_n = bus.music_en ? S_MUSIC : S_IDLE;
                            end
                        end else if (tick_c) begin
                            dur_n = dur - CNT_W'(1);
                        end
                    end else begin
                        state_n = bus.music_en ? S_MUSIC : S_IDLE;
                    end
                end
            end
        endcase

        sel_n  = (state_n == S_HALT) ? 3'd0 : state_n;
        busy_n = (state_n == S_GOOD) || (state_n == S_BAD) ||
                 (state_n == S_OVER) || (state_n == S_HALT);
    end

endmodule

// File: tb/tb_t06_sound_arbiter.sv
// Self-checking bench for t06_sound_arbiter: directed scenarios plus randomized traffic
// against a tick-counting behavioural model.
module tb_t06_sound_arbiter;

    localparam int DIV = 4;
    localparam int G_T = 3;
    localparam int B_T = 2;
    localparam int O_T = 5;

    localparam int K_IDLE  = 0;
    localparam int K_MUSIC = 1;
    localparam int K_GOOD  = 2;
    localparam int K_BAD   = 3;
    localparam int K_OVER  = 4;
    localparam int K_HALT  = 5;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic enable = 1'b0;
    logic music_en = 1'b0;
    logic good_req = 1'b0;
    logic bad_req = 1'b0;
    logic over_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: current sound, ticks still to play, pending flags, prescaler phase.
    int m_kind  = K_IDLE;
    int m_left  = 0;
    int m_phase = 0;
    bit m_gp    = 1'b0;
    bit m_bp    = 1'b0;

    t06_sound_arbiter_if bus();

    assign bus.enable   = enable;
    assign bus.music_en = music_en;
    assign bus.good_req = good_req;
    assign bus.bad_req  = bad_req;
    assign bus.over_req = over_req;

    t06_sound_arbiter #(
        .TICK_DIV  (DIV),
        .GOOD_TICKS(G_T),
        .BAD_TICKS (B_T),
        .OVER_TICKS(O_T),
        .CNT_W     (19)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic int rank(int k);
        case (k)
            K_GOOD:  return 1;
            K_BAD:   return 2;
            K_OVER:  return 3;
            K_HALT:  return 9;
            default: return 0;
        endcase
    endfunction

    function automatic int len_of(int k);
        case (k)
            K_GOOD:  return G_T;
            K_BAD:   return B_T;
            default: return O_T;
        endcase
    endfunction

    function automatic bit m_effect();
        return (m_kind == K_GOOD) || (m_kind == K_BAD) || (m_kind == K_OVER);
    endfunction

    function automatic logic [2:0] exp_sel();
        return (enable && m_kind != K_HALT) ? 3'(m_kind) : 3'd0;
    endfunction

    function automatic logic exp_tick();
        return enable && (m_phase == DIV - 1);
    endfunction

    function automatic logic exp_busy();
        return m_effect() || (m_kind == K_HALT);
    endfunction

    function automatic logic exp_done();
        return exp_tick() && m_effect() && (m_left == 1);
    endfunction

    task automatic model_reset();
        m_kind = K_IDLE; m_left = 0; m_phase = 0; m_gp = 1'b0; m_bp = 1'b0;
    endtask

    task automatic model_step();
        bit tk;
        bit fin;
        int top;
        tk  = exp_tick();
        fin = exp_done();
        if (enable) m_phase = (m_phase + 1) % DIV;
        if (m_kind == K_HALT) return;
        if (m_kind == K_OVER) begin
            if (over_req) m_left = O_T;
            else if (fin) m_kind = K_HALT;
            else if (tk) m_left--;
            return;
        end
        top = over_req ? K_OVER : bad_req ? K_BAD : good_req ? K_GOOD : -1;
        if (top >= 0 && rank(top) > rank(m_kind)) begin
            m_kind = top;
            m_left = len_of(top);
            if (top == K_OVER) begin
                m_gp = 1'b0; m_bp = 1'b0;
            end else if (top == K_BAD) begin
                m_bp = 1'b0;
                if (good_req) m_gp = 1'b1;
            end else begin
                m_gp = 1'b0;
            end
            return;
        end
        if (good_req && m_kind == K_BAD) m_gp = 1'b1;
        if (top == m_kind) begin
            m_left = len_of(top);
            return;
        end
        if (m_kind == K_GOOD || m_kind == K_BAD) begin
            if (fin) begin
                if (m_bp) begin
                    m_kind = K_BAD; m_left = B_T; m_bp = 1'b0;
                end else if (m_gp) begin
                    m_kind = K_GOOD; m_left = G_T; m_gp = 1'b0;
                end else begin
                    m_kind = music_en ? K_MUSIC : K_IDLE;
                end
            end else if (tk) begin
                m_left--;
            end
        end else begin
            m_kind = music_en ? K_MUSIC : K_IDLE;
        end
    endtask

    // Advance n clock edges, keeping the model in lockstep; returns at the negedge.
    task automatic cyc(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!nrst) model_reset();
            else model_step();
            @(negedge clk);
        end
    endtask

    // Bounded wait for done_o, counting ticks seen including the done cycle.
    task automatic wait_done(output int ticks, output bit seen);
        ticks = 0;
        seen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.tick_o === 1'b1) ticks++;
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b0; enable = 1'b1; music_en = 1'b1;
        model_reset();
        cyc(2);
        n_tests++; if (bus.sound_sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", bus.sound_sel); end
        n_tests++; if (bus.tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b expected 0", bus.tick_o); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done_o); end
    endtask

    task automatic test_music();
        int ticks;
        nrst = 1'b1;
        cyc();
        n_tests++; if (bus.sound_sel !== 3'd1) begin n_fail++; $display("FAIL music_sel: got %0d expected 1", bus.sound_sel); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL music_busy: got %0b expected 0", bus.busy); end
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.tick_o === 1'b1) ticks++;
            n_tests++; if (bus.tick_o !== exp_tick()) begin n_fail++; $display("FAIL music_tick: got %0b expected %0b", bus.tick_o, exp_tick()); end
        end
        n_tests++; if (ticks != 2) begin n_fail++; $display("FAIL music_tick_rate: got %0d ticks expected 2", ticks); end
    endtask

    task automatic test_good();
        int ticks;
        bit seen;
        good_req = 1'b1; cyc(); good_req = 1'b0;
        n_tests++; if (bus.sound_sel !== 3'd2) begin n_fail++; $display("FAIL good_sel: got %0d expected 2", bus.sound_sel); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %0b expected 1", bus.busy); end
        wait_done(ticks, seen);
        n_tests++; if (!seen || ticks != G_T) begin n_fail++; $display("FAIL good_ticks: got %0d (done seen %0b) expected %0d", ticks, seen, G_T); end
        cyc();
        n_tests++; if (bus.sound_sel !== 3'd1) begin n_fail++; $display("FAIL good_back_music: got %0d expected 1", bus.sound_sel); end
    endtask

    task automatic test_preempt();
        int ticks;
        bit seen;
        int dones;
        music_en = 1'b0;
        good_req = 1'b1; cyc(); good_req = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done_o === 1'b1) dones++;
            cyc();
        end
        bad_req = 1'b1; cyc(); bad_req = 1'b0;
        n_tests++; if (bus.sound_sel !== 3'd3) begin n_fail++; $display("FAIL preempt_sel: got %0d expected 3", bus.sound_sel); end
        wait_done(ticks, seen);
        n_tests++; if (!seen || ticks != B_T || dones != 0) begin n_fail++; $display("FAIL preempt_bad_ticks: got %0d (done seen %0b, early dones %0d) expected %0d", ticks, seen, dones, B_T); end
        cyc();
        n_tests++; if (bus.sound_sel !== 3'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL preempt_idle: got sel %0d busy %0b expected sel 0 busy 0", bus.sound_sel, bus.busy); end
    endtask

    task automatic test_pending();
        int ticks;
        bit seen;
        bad_req = 1'b1; cyc(); bad_req = 1'b0;
        cyc();
        good_req = 1'b1; cyc(); good_req = 1'b0;
        n_tests++; if (bus.sound_sel !== 3'd3) begin n_fail++; $display("FAIL pend_stay_bad: got %0d expected 3", bus.sound_sel); end
        wait_done(ticks, seen);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL pend_bad_done: got %0b expected 1", seen); end
        cyc();
        n_tests++; if (bus.sound_sel !== 3'd2) begin n_fail++; $display("FAIL pend_good_sel: got %0d expected 2", bus.sound_sel); end
        wait_done(ticks, seen);
        n_tests++; if (!seen || ticks != G_T) begin n_fail++; $display("FAIL pend_good_ticks: got %0d (done seen %0b) expected %0d", ticks, seen, G_T); end
        cyc();
        n_tests++; if (bus.sound_sel !== 3'd0) begin n_fail++; $display("FAIL pend_idle: got %0d expected 0", bus.sound_sel); end
    endtask

    task automatic test_over();
        int ticks;
        bit seen;
        good_req = 1'b1; bad_req = 1'b1; over_req = 1'b1;
        cyc();
        good_req = 1'b0; bad_req = 1'b0; over_req = 1'b0;
        n_tests++; if (bus.sound_sel !== 3'd4) begin n_fail++; $display("FAIL over_sel: got %0d expected 4", bus.sound_sel); end
        wait_done(ticks, seen);
        n_tests++; if (!seen || ticks != O_T) begin n_fail++; $display("FAIL over_ticks: got %0d (done seen %0b) expected %0d", ticks, seen, O_T); end
        cyc();
        n_tests++; if (bus.sound_sel !== 3'd0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL over_halt: got sel %0d busy %0b expected sel 0 busy 1", bus.sound_sel, bus.busy); end
        good_req = 1'b1; cyc(); good_req = 1'b0;
        bad_req = 1'b1; cyc(); bad_req = 1'b0;
        cyc(6);
        n_tests++; if (bus.sound_sel !== 3'd0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL halt_ignore: got sel %0d busy %0b expected sel 0 busy 1", bus.sound_sel, bus.busy); end
    endtask

    task automatic test_enable_hold();
        int ticks;
        bit seen;
        nrst = 1'b0; model_reset(); cyc(); nrst = 1'b1;
        music_en = 1'b0; enable = 1'b1;
        good_req = 1'b1; cyc(); good_req = 1'b0;
        for (int i = 0; i < 8 && bus.tick_o !== 1'b1; i++) cyc();
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++; if (bus.sound_sel !== 3'd0 || bus.tick_o !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL mute_hold: got sel %0d tick %0b busy %0b expected sel 0 tick 0 busy 1", bus.sound_sel, bus.tick_o, bus.busy);
            end
        end
        enable = 1'b1;
        #1;
        n_tests++; if (bus.sound_sel !== 3'd2) begin n_fail++; $display("FAIL resume_sel: got %0d expected 2", bus.sound_sel); end
        wait_done(ticks, seen);
        n_tests++; if (!seen || ticks != G_T - 1) begin n_fail++; $display("FAIL resume_ticks: got %0d (done seen %0b) expected %0d", ticks, seen, G_T - 1); end
    endtask

    task automatic test_reset_mid();
        cyc();
        good_req = 1'b1; cyc(); good_req = 1'b0;
        cyc(2);
        #2 nrst = 1'b0;
        model_reset();
        #1;
        n_tests++; if (bus.sound_sel !== 3'd0 || bus.busy !== 1'b0 || bus.tick_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got sel %0d busy %0b tick %0b done %0b expected all 0", bus.sound_sel, bus.busy, bus.tick_o, bus.done_o);
        end
        @(negedge clk);
        cyc();
        nrst = 1'b1;
        cyc();
        n_tests++; if (bus.sound_sel !== 3'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL after_reset_mid: got sel %0d busy %0b expected 0 0", bus.sound_sel, bus.busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) music_en = ~music_en;
            good_req = ($urandom_range(0, 14) == 0);
            bad_req  = ($urandom_range(0, 19) == 0);
            over_req = ($urandom_range(0, 99) == 0);
            if ((m_kind == K_HALT && $urandom_range(0, 11) == 0) || $urandom_range(0, 299) == 0) begin
                nrst = 1'b0;
                model_reset();
            end else begin
                nrst = 1'b1;
            end
            #1;
            n_tests++; if (bus.sound_sel !== exp_sel()) begin n_fail++; $display("FAIL rand_sel @%0d: got %0d expected %0d", i, bus.sound_sel, exp_sel()); end
            n_tests++; if (bus.tick_o !== exp_tick()) begin n_fail++; $display("FAIL rand_tick @%0d: got %0b expected %0b", i, bus.tick_o, exp_tick()); end
            n_tests++; if (bus.busy !== exp_busy()) begin n_fail++; $display("FAIL rand_busy @%0d: got %0b expected %0b", i, bus.busy, exp_busy()); end
            n_tests++; if (bus.done_o !== exp_done()) begin n_fail++; $display("FAIL rand_done @%0d: got %0b expected %0b", i, bus.done_o, exp_done()); end
            cyc();
        end
        good_req = 1'b0; bad_req = 1'b0; over_req = 1'b0; nrst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_music();
        test_good();
        test_preempt();
        test_pending();
        test_over();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
